// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (instruction fetch, load/store) and one
// shared SRAM-like slave.
//
//   inst_*  : fetch port (read only)
//   data_*  : load/store port
//   m_*     : request to / response from the shared slave
//
// Modports:
//   master : the arbiter's view (takes requests and slave responses,
//            drives handshakes and the slave request)
//   slave  : the surrounding environment's view (everything reversed)
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter putting an instruction port and a data port onto one
// SRAM-like slave, one transaction outstanding at a time.
//
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : mem_arbiter_if.master (requester ports + slave request/response)
//
// Parameter:
//   PRIO_DATA : 1 = data port wins every tie, 0 = ties alternate
module mem_arbiter #(
    parameter int PRIO_DATA = 1
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_data;   // 1: current transaction belongs to data port
    logic        last_data;    // 1: most recent grant went to data port
    logic        any_req;
    logic        grant_data;
    logic        addr_hs;
    logic        data_hs;

    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Data wins when alone, when data is prioritised, or on a tie when the
    // previous grant went to the instruction port.
    always_comb begin
        any_req    = bus.inst_req || bus.data_req;
        grant_data = bus.data_req &&
                     (!bus.inst_req || (PRIO_DATA != 0) || !last_data);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = ADDR;
            ADDR: if (bus.m_addr_ok) state_nxt = bus.m_data_ok ? IDLE : DATA;
            DATA: if (bus.m_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Owner and payload are captured only at grant, so the requester may drop
    // its request afterwards without disturbing the slave request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_data <= 1'b0;
            last_data  <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= 2'b00;
            lat_wstrb  <= 4'b0000;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
        end else if (state == IDLE && any_req) begin
            owner_data <= grant_data;
            last_data  <= grant_data;
            if (grant_data) begin
                lat_wr    <= bus.data_wr;
                lat_size  <= bus.data_size;
                lat_wstrb <= bus.data_wstrb;
                lat_addr  <= bus.data_addr;
                lat_wdata <= bus.data_wdata;
            end else begin
                lat_wr    <= 1'b0;
                lat_size  <= 2'b10;
                lat_wstrb <= 4'b0000;
                lat_addr  <= bus.inst_addr;
                lat_wdata <= 32'd0;
            end
        end
    end

    // A data_ok only counts once the address phase has been accepted, either
    // in the same ADDR cycle or later in DATA; anything else is stray.
    always_comb begin
        addr_hs = (state == ADDR) && bus.m_addr_ok;
        data_hs = (addr_hs || (state == DATA)) && bus.m_data_ok;
    end

    assign bus.m_req        = (state == ADDR);
    assign bus.m_wr         = lat_wr;
    assign bus.m_size       = lat_size;
    assign bus.m_wstrb      = lat_wstrb;
    assign bus.m_addr       = lat_addr;
    assign bus.m_wdata      = lat_wdata;

    assign bus.inst_addr_ok = addr_hs && !owner_data;
    assign bus.inst_data_ok = data_hs && !owner_data;
    assign bus.data_addr_ok = addr_hs &&  owner_data;
    assign bus.data_data_ok = data_hs &&  owner_data;

    assign bus.inst_rdata   = bus.m_rdata;
    assign bus.data_rdata   = bus.m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with data priority and one
// with round-robin tie breaking, sharing clock and reset.
module tb_mem_arbiter;
    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;

    mem_arbiter_if b ();
    mem_arbiter_if r ();

    mem_arbiter #(.PRIO_DATA(1)) u_pd (.clk(clk), .resetn(resetn), .bus(b.master));
    mem_arbiter #(.PRIO_DATA(0)) u_rr (.clk(clk), .resetn(resetn), .bus(r.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_b();
        b.inst_req = 0; b.inst_addr = 0;
        b.data_req = 0; b.data_wr = 0; b.data_size = 0; b.data_wstrb = 0;
        b.data_addr = 0; b.data_wdata = 0;
        b.m_addr_ok = 0; b.m_data_ok = 0; b.m_rdata = 0;
    endtask

    task automatic clear_r();
        r.inst_req = 0; r.inst_addr = 0;
        r.data_req = 0; r.data_wr = 0; r.data_size = 0; r.data_wstrb = 0;
        r.data_addr = 0; r.data_wdata = 0;
        r.m_addr_ok = 0; r.m_data_ok = 0; r.m_rdata = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        resetn = 1'b0;
        clear_b();
        clear_r();

        // Reset: requests and slave responses must not leak through
        repeat (2) @(negedge clk);
        b.inst_req = 1; b.inst_addr = 32'h1234_5678;
        b.m_addr_ok = 1; b.m_data_ok = 1;
        #1;
        chk("rst_m_req",     32'(b.m_req), 0);
        chk("rst_i_addr_ok", 32'(b.inst_addr_ok), 0);
        chk("rst_i_data_ok", 32'(b.inst_data_ok), 0);
        chk("rst_m_addr",    b.m_addr, 0);
        @(negedge clk);
        clear_b();
        resetn = 1'b1;
        @(negedge clk);

        // Single fetch
        b.inst_req = 1; b.inst_addr = 32'hBFC0_0000;
        #1 chk("f_idle_m_req", 32'(b.m_req), 0);
        @(negedge clk);
        b.inst_req = 0; b.m_addr_ok = 1;
        #1;
        chk("f_m_req",     32'(b.m_req), 1);
        chk("f_m_addr",    b.m_addr, 32'hBFC0_0000);
        chk("f_m_wr",      32'(b.m_wr), 0);
        chk("f_m_size",    32'(b.m_size), 2);
        chk("f_i_addr_ok", 32'(b.inst_addr_ok), 1);
        chk("f_d_addr_ok", 32'(b.data_addr_ok), 0);
        chk("f_i_data_ok0", 32'(b.inst_data_ok), 0);
        @(negedge clk);
        b.m_addr_ok = 0; b.m_data_ok = 1; b.m_rdata = 32'h3C08_BFAF;
        #1;
        chk("f_i_data_ok", 32'(b.inst_data_ok), 1);
        chk("f_i_rdata",   b.inst_rdata, 32'h3C08_BFAF);
        chk("f_d_data_ok", 32'(b.data_data_ok), 0);
        chk("f_data_m_req", 32'(b.m_req), 0);
        @(negedge clk);
        b.m_data_ok = 0;
        #1 chk("f_back_idle", 32'(b.m_req), 0);

        // Tie with data priority: store first, fetch 3 cycles later
        @(negedge clk);
        b.inst_req = 1; b.inst_addr = 32'hBFC0_0004;
        b.data_req = 1; b.data_wr = 1; b.data_size = 2'b00; b.data_wstrb = 4'b0100;
        b.data_addr = 32'h8000_1002; b.data_wdata = 32'h00AB_0000;
        b.m_addr_ok = 1;
        @(negedge clk);
        b.data_req = 0;
        #1;
        chk("t_m_req",     32'(b.m_req), 1);
        chk("t_m_wr",      32'(b.m_wr), 1);
        chk("t_m_size",    32'(b.m_size), 0);
        chk("t_m_wstrb",   32'(b.m_wstrb), 32'h4);
        chk("t_m_addr",    b.m_addr, 32'h8000_1002);
        chk("t_m_wdata",   b.m_wdata, 32'h00AB_0000);
        chk("t_d_addr_ok", 32'(b.data_addr_ok), 1);
        chk("t_i_addr_ok", 32'(b.inst_addr_ok), 0);
        @(negedge clk);
        b.m_data_ok = 1;
        #1;
        chk("t_d_data_ok", 32'(b.data_data_ok), 1);
        chk("t_i_data_ok", 32'(b.inst_data_ok), 0);
        @(negedge clk);
        b.m_data_ok = 0;
        #1 chk("t_idle_m_req", 32'(b.m_req), 0);
        @(negedge clk);
        b.inst_req = 0;
        #1;
        chk("t2_m_req",     32'(b.m_req), 1);
        chk("t2_m_addr",    b.m_addr, 32'hBFC0_0004);
        chk("t2_m_wr",      32'(b.m_wr), 0);
        chk("t2_m_wstrb",   32'(b.m_wstrb), 0);
        chk("t2_i_addr_ok", 32'(b.inst_addr_ok), 1);
        @(negedge clk);
        b.m_data_ok = 1; b.m_rdata = 32'h1234_5678;
        #1;
        chk("t2_i_data_ok", 32'(b.inst_data_ok), 1);
        chk("t2_i_rdata",   b.inst_rdata, 32'h1234_5678);
        @(negedge clk);
        clear_b();

        // Slave stalls address phase for 5 cycles; stray data_ok ignored
        b.data_req = 1; b.data_wr = 0; b.data_size = 2'b10;
        b.data_addr = 32'h8000_0010;
        @(negedge clk);
        b.data_req = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin b.inst_req = 1; b.inst_addr = 32'hBFC0_0100; end
            b.m_data_ok = (i == 2);
            #1;
            chk("s_m_req",     32'(b.m_req), 1);
            chk("s_m_addr",    b.m_addr, 32'h8000_0010);
            chk("s_d_addr_ok", 32'(b.data_addr_ok), 0);
            chk("s_d_data_ok", 32'(b.data_data_ok), 0);
            @(negedge clk);
        end
        b.m_data_ok = 0; b.m_addr_ok = 1;
        #1;
        chk("s_d_addr_ok6", 32'(b.data_addr_ok), 1);
        chk("s_i_addr_ok6", 32'(b.inst_addr_ok), 0);
        @(negedge clk);
        b.m_addr_ok = 0; b.m_data_ok = 1; b.m_rdata = 32'hCAFE_F00D;
        #1;
        chk("s_d_data_ok", 32'(b.data_data_ok), 1);
        chk("s_d_rdata",   b.data_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        b.m_data_ok = 0;
        #1 chk("s_idle_m_req", 32'(b.m_req), 0);

        // Pending fetch: addr_ok and data_ok together in ADDR
        @(negedge clk);
        b.inst_req = 0; b.m_addr_ok = 1; b.m_data_ok = 1; b.m_rdata = 32'h0BAD_BEEF;
        #1;
        chk("c_m_addr",     b.m_addr, 32'hBFC0_0100);
        chk("c_i_addr_ok",  32'(b.inst_addr_ok), 1);
        chk("c_i_data_ok",  32'(b.inst_data_ok), 1);
        chk("c_i_rdata",    b.inst_rdata, 32'h0BAD_BEEF);
        @(negedge clk);
        b.m_addr_ok = 0;
        #1;
        chk("c_idle_m_req",  32'(b.m_req), 0);
        chk("c_stray_dok",   32'(b.inst_data_ok), 0);
        @(negedge clk);
        clear_b();

        // Reset during DATA abandons the transaction
        b.data_req = 1; b.data_addr = 32'h8000_0020; b.data_size = 2'b10;
        @(negedge clk);
        b.data_req = 0; b.m_addr_ok = 1;
        #1 chk("r_d_addr_ok", 32'(b.data_addr_ok), 1);
        @(negedge clk);
        b.m_addr_ok = 0;
        #1;
        chk("r_data_m_req", 32'(b.m_req), 0);
        chk("r_d_data_ok0", 32'(b.data_data_ok), 0);
        #1 resetn = 1'b0;
        #1 chk("r_async_addr", b.m_addr, 0);
        @(negedge clk);
        resetn = 1'b1;
        b.m_data_ok = 1;
        b.data_req = 1; b.data_addr = 32'h8000_0040;
        #1;
        chk("r_stray_dok", 32'(b.data_data_ok), 0);
        chk("r_idle_m_req", 32'(b.m_req), 0);
        @(negedge clk);
        b.data_req = 0; b.m_data_ok = 0; b.m_addr_ok = 1;
        #1;
        chk("r_first_m_req",  32'(b.m_req), 1);
        chk("r_first_m_addr", b.m_addr, 32'h8000_0040);
        @(negedge clk);
        b.m_addr_ok = 0; b.m_data_ok = 1;
        #1 chk("r_first_dok", 32'(b.data_data_ok), 1);
        @(negedge clk);
        clear_b();

        // Both held on both instances: round-robin alternates, priority does not
        r.inst_req = 1; r.inst_addr = 32'h0000_1000;
        r.data_req = 1; r.data_addr = 32'h0000_2000;
        r.m_addr_ok = 1; r.m_data_ok = 1;
        b.inst_req = 1; b.inst_addr = 32'h0000_1000;
        b.data_req = 1; b.data_addr = 32'h0000_2000;
        b.m_addr_ok = 1; b.m_data_ok = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("rr_m_req",     32'(r.m_req), 1);
            chk("rr_m_addr",    r.m_addr, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
            chk("rr_d_data_ok", 32'(r.data_data_ok), (k % 2 == 0) ? 1 : 0);
            chk("rr_i_data_ok", 32'(r.inst_data_ok), (k % 2 == 0) ? 0 : 1);
            chk("pd_m_addr",    b.m_addr, 32'h0000_2000);
            chk("pd_i_addr_ok", 32'(b.inst_addr_ok), 0);
            @(negedge clk);
            #1 chk("rr_idle_m_req", 32'(r.m_req), 0);
        end
        clear_b();
        clear_r();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
